// File: rtl/uart_rx_8n1_os.sv
// UART 8N1 receiver, 16x oversampled with its own tick divider.
// Ports: clk, rst (sync, active high), rx line in; rx_data/rx_valid
// holding register with rx_ack handshake; frame_err pulse, overrun
// sticky flag, busy while a frame is in progress.
module uart_rx_8n1_os #(
  parameter int CLK_FREQ   = 48000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        =
    (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_n;

  logic          s1;
  logic          rxs;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    scnt;
  logic          smp7;
  logic          smp8;
  logic          sample;
  logic          decide;
  logic          go;
  logic [7:0]    sh;
  logic [2:0]    bit_idx;
  logic          load;
  logic          ferr;
  logic          shift_en;
  logic          enter_data;

  assign tick   = (div_cnt == DIV_LAST);
  // decision taken on the tick that moves the counter to 9
  assign decide = tick && (scnt == 4'd8);
  assign sample = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);
  assign go     = (state == IDLE) && !rxs;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    ferr       = 1'b0;
    shift_en   = 1'b0;
    enter_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) state_n = START;
      end
      START: begin
        if (decide) begin
          if (sample) begin
            state_n = IDLE;
          end else begin
            state_n    = DATA;
            enter_data = 1'b1;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (sample) begin
            load    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // a held-low break must not retrigger a start
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      rxs       <= 1'b1;
      div_cnt   <= '0;
      scnt      <= 4'd0;
      smp7      <= 1'b1;
      smp8      <= 1'b1;
      sh        <= 8'h00;
      bit_idx   <= 3'd0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      s1  <= rx;
      rxs <= s1;

      // realign tick phase to the start edge
      if (go) begin
        div_cnt <= '0;
        scnt    <= 4'd0;
      end else begin
        if (tick) begin
          div_cnt <= '0;
          scnt    <= scnt + 4'd1;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end

      if (tick && scnt == 4'd6) smp7 <= rxs;
      if (tick && scnt == 4'd7) smp8 <= rxs;

      if (enter_data) bit_idx <= 3'd0;
      if (shift_en) begin
        sh      <= {sample, sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      frame_err <= ferr;

      if (load) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
        if (rx_ack)        overrun <= 1'b0;
        else if (rx_valid) overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1_os.sv
// Scoreboard bench for uart_rx_8n1_os.
// Clock-aligned serial driver; monitor pops expected bytes.
`timescale 1ns/1ps
module tb_uart_rx_8n1_os;

  localparam int CLKF = 14745600;
  localparam int DIV  = 8;
  localparam int BIT  = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_8n1_os #(.CLK_FREQ(CLKF)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ack(rx_ack),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic       pv;
    logic [7:0] pd;
    logic [7:0] e;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk);
      if (frame_err) ferr_cnt++;
      if (rx_valid && (!pv || rx_data != pd)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected byte: got %0h expected none",
                   rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx byte", int'(rx_data), int'(e));
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  endtask

  task automatic send(input logic [7:0] b, input int clks,
                      input logic stop, input int spk);
    rx = 1'b0;
    repeat (clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == spk) begin
        repeat (7 * DIV + DIV / 2) @(negedge clk);
        rx = ~b[i];
        repeat (DIV - 1) @(negedge clk);
        rx = b[i];
        repeat (clks - 8 * DIV - DIV / 2 + 1) @(negedge clk);
      end else begin
        repeat (clks) @(negedge clk);
      end
    end
    rx = stop;
    repeat (clks) @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rx_valid && lat < 15 * BIT) begin
      @(negedge clk);
      lat++;
    end
    if (!rx_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL valid timeout: got 0 expected 1");
    end
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    int lat;
    int lat0;
    int f0;
    logic [7:0] lb [4];
    lb = '{8'h00, 8'h55, 8'hFF, 8'h80};
    fork
      monitor();
    join_none

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset rx_valid", int'(rx_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(overrun), 0);
    repeat (BIT) @(negedge clk);

    // single byte with latency
    exp_q.push_back(8'hA5);
    fork
      send(8'hA5, BIT, 1'b1, -1);
      wait_valid(lat0);
    join
    chk("a5 latency ok",
        int'(lat0 >= (94 * BIT) / 10 && lat0 <= (97 * BIT) / 10), 1);
    ack();
    chk("ack clears valid", int'(rx_valid), 0);
    chk("a5 frame_err", ferr_cnt, 0);
    chk("a5 overrun", int'(overrun), 0);

    // loopback sequence
    foreach (lb[i]) begin
      exp_q.push_back(lb[i]);
      send(lb[i], BIT, 1'b1, -1);
      wait_valid(lat);
      ack();
    end
    chk("loop overrun", int'(overrun), 0);
    chk("loop frame_err", ferr_cnt, 0);

    // start glitch
    rx = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch busy high", int'(busy), 1);
    repeat (3 * BIT) @(negedge clk);
    chk("glitch busy low", int'(busy), 0);
    chk("glitch no valid", int'(rx_valid), 0);

    // spike inside data bit 2
    exp_q.push_back(8'h3C);
    send(8'h3C, BIT, 1'b1, 2);
    wait_valid(lat);
    ack();

    // framing error then break
    f0 = ferr_cnt;
    send(8'h12, BIT, 1'b0, -1);
    repeat (20 * BIT) @(negedge clk);
    chk("break busy", int'(busy), 1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("bad frame not delivered", int'(rx_valid), 0);
    exp_q.push_back(8'h34);
    send(8'h34, BIT, 1'b1, -1);
    wait_valid(lat);
    chk("frame_err pulses", ferr_cnt - f0, 1);
    chk("after break data", int'(rx_data), 'h34);
    ack();

    // overrun back-to-back
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send(8'h11, BIT, 1'b1, -1);
    send(8'h22, BIT, 1'b1, -1);
    chk("overrun set", int'(overrun), 1);
    chk("overrun data", int'(rx_data), 'h22);
    ack();
    chk("overrun ack valid", int'(rx_valid), 0);
    chk("overrun ack flag", int'(overrun), 0);

    // ack in the load cycle
    exp_q.push_back(8'h11);
    send(8'h11, BIT, 1'b1, -1);
    repeat (BIT) @(negedge clk);
    exp_q.push_back(8'h22);
    fork
      send(8'h22, BIT, 1'b1, -1);
      begin
        repeat (lat0 - 1) @(negedge clk);
        ack();
        chk("ackload valid", int'(rx_valid), 1);
        chk("ackload data", int'(rx_data), 'h22);
        chk("ackload overrun", int'(overrun), 0);
      end
    join

    // reset during bit 4 of 0xF0
    fork
      send(8'hF0, BIT, 1'b1, -1);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst data", int'(rx_data), 0);
        chk("mid rst valid", int'(rx_valid), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst ovr", int'(overrun), 0);
        chk("mid rst ferr", int'(frame_err), 0);
      end
    join
    repeat (2 * BIT) @(negedge clk);
    chk("after rst no valid", int'(rx_valid), 0);

    // transmitter rate error +3% / -3%
    exp_q.push_back(8'h5A);
    send(8'h5A, 124, 1'b1, -1);
    wait_valid(lat);
    ack();
    repeat (BIT) @(negedge clk);
    exp_q.push_back(8'h5A);
    send(8'h5A, 132, 1'b1, -1);
    wait_valid(lat);
    ack();
    repeat (BIT) @(negedge clk);

    chk("scoreboard drained", exp_q.size(), 0);
    chk("final frame_err count", ferr_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1_os.md
Name: uart_rx_8n1_os

Overview:
- UART 8N1 receiver, the receive-side counterpart to the team's uart_tx_8n1.
- Synchronises the asynchronous rx line and oversamples it at 16x baud from the system clock, using its own internal tick divider (no external baud clock).
- Delivers each received byte through a one-entry holding register with a valid/ack handshake, plus frame-error and overrun flags.
- Used for loopback tests against the transmitter and as the host-command input path.

Parameters:
- CLK_FREQ, 48000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: samples per bit. Fixed at 16; the sample indices below assume it.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest (26 at defaults): clk cycles per oversample tick. Must be >= 2.

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  synchronous active-high reset
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  8  last received byte, LSB = first data bit on the line
- rx_valid  output  1  holding register full; level, held until acknowledged
- rx_ack  input  1  consumer acknowledge; clears rx_valid in the cycle after it is sampled high
- frame_err  output  1  one-clk pulse when a stop bit is sampled low
- overrun  output  1  sticky; set when a byte completes while rx_valid=1 and rx_ack=0; cleared by rx_ack or rst
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0;
  - synchroniser flops=1, tick divider=0, sample counter=0.
  - Applies mid-frame; the partial byte is discarded.
- Synchroniser: 2-flop chain on rx; all logic uses the second-flop output rxs.
  - Input-to-rxs latency is 2 clk.
- Tick generator: counter 0..DIV-1, free-running; emits a 1-clk tick at DIV-1.
  - Reset to 0 when leaving IDLE, so sample timing is phase-aligned to the start edge within 1 clk.
- Sample counter: 4 bits, advances on each tick, wraps 15->0.
  - Sample value = majority of rxs at sample-counter values 7, 8 and 9.
  - The bit decision is taken at the tick where the counter reaches 9.
- State IDLE:
  - On rxs=0 (falling edge, since the line idles high): go to START, clear the sample counter.
- State START:
  - At the bit decision, sample=1 means a glitch: return to IDLE with no flags raised.
  - Sample=0: go to DATA with bit index 0.
  - Decisions for each following bit fall at counter 9, 16 ticks apart.
- State DATA:
  - Each decision shifts the sample in at the MSB of the shift register (right shift), so LSB-first order is restored.
  - After bit index 7, go to STOP.
- State STOP, sample=1: load rx_data from the shift register and set rx_valid=1, both in the same clk; go to IDLE.
  - If rx_valid was already 1 and rx_ack=0 that cycle: overwrite rx_data and set overrun.
  - If rx_ack=1 in the same cycle: load the new byte, rx_valid stays 1, no overrun.
- State STOP, sample=0: pulse frame_err for 1 clk, discard the byte (rx_valid and rx_data unchanged), go to WAIT_HIGH.
- State WAIT_HIGH: remain until rxs=1, then go to IDLE. This prevents a break condition from retriggering START.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid next clk.
  - rx_ack while rx_valid=0 has no effect except clearing overrun.
  - rx_data remains stable while rx_valid=1 unless overwritten as above.
- Tolerance: the receiver must decode correctly with transmitter rate error up to ±3%.
- Back-to-back frames (stop bit followed immediately by a start bit): must be received with no lost byte.
  - IDLE is re-entered at mid-stop-bit, before the next falling edge.

Test Plan:
- Single byte: after reset, drive 0xA5 at 115200 baud (8680 ns per bit) -> rx_valid rises about 9.5 bit times after the start edge, rx_data=0xA5; rx_ack for 1 clk -> rx_valid=0 next clk; frame_err=0, overrun=0.
- Loopback: uart_tx_8n1 drives rx with bytes 0x00, 0x55, 0xFF, 0x80, acknowledging each -> identical byte sequence received, no flags.
- Glitch and noise:
  - 2-tick low pulse while idle -> no rx_valid, state returns to IDLE, busy falls.
  - 1-tick inverted spike in the middle of a data bit of 0x3C -> rx_data=0x3C (majority vote).
- Framing: send 0x12 with stop bit low, then hold rx low 20 bit times, then send 0x34 -> one frame_err pulse, nothing delivered for the bad frame, then rx_data=0x34 with rx_valid=1.
- Overrun:
  - Send 0x11 then 0x22 back-to-back without ack -> rx_data=0x22, overrun=1; rx_ack clears both.
  - Repeat with rx_ack asserted exactly at the second byte's load cycle -> rx_data=0x22, rx_valid=1, overrun=0.
- Reset mid-frame and rate error: assert rst during bit 4 of 0xF0 -> all outputs 0 next clk; then send 0x5A with the transmitter at +3% and at -3% baud -> 0x5A received correctly both times.
